// File: rtl/ram_bank_pkg.sv
// Shared defaults and word type for the scratch RAM bank.
package ram_bank_pkg;

    localparam int RAM_ADDR_BIT   = 3;
    localparam int RAM_DATA_BIT   = 16;
    localparam int RAM_MEM_HEIGHT = 8;

    typedef logic [RAM_DATA_BIT-1:0] ram_word_t;

endpackage

// File: rtl/ram_bank_array.sv
// Storage array: synchronous range-checked write, synchronous clear, and
// a combinational read of the addressed word.
module ram_bank_array
    import ram_bank_pkg::*;
#(
    parameter int ADDR_BIT   = RAM_ADDR_BIT,
    parameter int DATA_BIT   = RAM_DATA_BIT,
    parameter int MEM_HEIGHT = RAM_MEM_HEIGHT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_BIT-1:0] addr_w,
    input  logic [DATA_BIT-1:0] d_w,
    input  logic [ADDR_BIT-1:0] addr_r,
    output logic [DATA_BIT-1:0] rd_word,
    output logic                w_in_range
);

    // One extra bit so MEM_HEIGHT == 2**ADDR_BIT is representable.
    localparam logic [ADDR_BIT:0] HEIGHT = (ADDR_BIT+1)'(MEM_HEIGHT);

    logic [DATA_BIT-1:0] mem [MEM_HEIGHT];
    logic                r_in_range;

    assign w_in_range = {1'b0, addr_w} < HEIGHT;
    assign r_in_range = {1'b0, addr_r} < HEIGHT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_HEIGHT; i++) mem[i] <= '0;
        end else if (wr_en && w_in_range) begin
            mem[addr_w] <= d_w;
        end
    end

    assign rd_word = r_in_range ? mem[addr_r] : '0;

endmodule

// File: rtl/ram_bank.sv
// Simple dual-port RAM bank with a registered, write-first read port and a
// global enable gating both ports.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int ADDR_BIT   = RAM_ADDR_BIT,
    parameter int DATA_BIT   = RAM_DATA_BIT,
    parameter int MEM_HEIGHT = RAM_MEM_HEIGHT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_BIT-1:0] addr_w,
    input  logic [DATA_BIT-1:0] d_w,
    input  logic [ADDR_BIT-1:0] addr_r,
    output logic [DATA_BIT-1:0] d_r
);

    logic                wr_en;
    logic                rd_en;
    logic                w_in_range;
    logic                bypass;
    logic [DATA_BIT-1:0] rd_word;
    logic [DATA_BIT-1:0] rd_next;

    assign wr_en = en & we;
    assign rd_en = en & re;

    ram_bank_array #(
        .ADDR_BIT  (ADDR_BIT),
        .DATA_BIT  (DATA_BIT),
        .MEM_HEIGHT(MEM_HEIGHT)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .addr_w    (addr_w),
        .d_w       (d_w),
        .addr_r    (addr_r),
        .rd_word   (rd_word),
        .w_in_range(w_in_range)
    );

    // Same-address collision returns the incoming word; an out-of-range
    // write never bypasses, so the read still sees zero.
    assign bypass  = wr_en && w_in_range && (addr_w == addr_r);
    assign rd_next = bypass ? d_w : rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_r <= '0;
        end else if (rd_en) begin
            d_r <= rd_next;
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: full-height and short-height instances share stimulus
// and are compared every cycle against a behavioural model.
module tb_ram_bank;
    import ram_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, we, re;
    logic [2:0]  addr_w, addr_r;
    ram_word_t   d_w;
    ram_word_t   dr_big, dr_small;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bank #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8)) u_big (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .re(re),
        .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r), .d_r(dr_big)
    );

    ram_bank #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(5)) u_small (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .re(re),
        .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r), .d_r(dr_small)
    );

    // Behavioural model: index 0 = 8-word bank, index 1 = 5-word bank.
    logic [15:0] mm [2][8];
    logic [15:0] md [2];
    int          hgt [2] = '{8, 5};
    bit          mvalid = 0;

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) mm[n][i] = 16'h0;
                md[n] = 16'h0;
            end else if (en) begin
                if (re) begin
                    if (int'(addr_r) >= hgt[n])        md[n] = 16'h0;
                    else if (we && addr_w == addr_r)   md[n] = d_w;
                    else                               md[n] = mm[n][addr_r];
                end
                if (we && int'(addr_w) < hgt[n]) mm[n][addr_w] = d_w;
            end
        end
        mvalid = 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("dr_big_vs_model", dr_big, md[0]);
            chk("dr_small_vs_model", dr_small, md[1]);
        end
    end

    // Hand-computed expectation on the full bank, pinning DUT and model.
    task automatic lit(input string name, input logic [15:0] exp);
        chk({name, "_dut"}, dr_big, exp);
        chk({name, "_model"}, md[0], exp);
    endtask

    task automatic lit_small(input string name, input logic [15:0] exp);
        chk({name, "_small"}, dr_small, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic w, input logic rd,
                        input logic [2:0] aw, input logic [15:0] dw, input logic [2:0] ar);
        rst_n = r; en = e; we = w; re = rd; addr_w = aw; d_w = dw; addr_r = ar;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] ar);
        step(1, 1, 0, 1, 3'd0, 16'h0, ar);
    endtask

    initial begin
        rst_n = 0; en = 0; we = 0; re = 0; addr_w = 0; d_w = 0; addr_r = 0;

        // Reset then idle
        step(0, 0, 0, 0, 3'd0, 16'h0, 3'd0);
        step(0, 0, 0, 0, 3'd0, 16'h0, 3'd0);
        lit("reset_dr", 16'h0);
        lit_small("reset_dr", 16'h0);
        repeat (3) step(1, 0, 0, 0, 3'd0, 16'h0, 3'd0);
        lit("idle_dr", 16'h0);
        rd(3'd4);
        lit("post_reset_read4", 16'h0);

        // Sequential fill, read port off
        for (int k = 0; k < 8; k++) step(1, 1, 1, 0, 3'(k), 16'(k), 3'd0);
        lit("after_fill_dr", 16'h0);

        // Sequential readback; short bank returns 0 beyond its height
        for (int k = 0; k < 8; k++) begin
            rd(3'(k));
            lit($sformatf("readback%0d", k), 16'(k));
            lit_small($sformatf("readback%0d", k), (k < 5) ? 16'(k) : 16'h0);
        end

        // Same-address read-during-write is write-first
        step(1, 1, 1, 1, 3'd3, 16'd10, 3'd3);
        lit("rdw_same", 16'd10);
        lit_small("rdw_same", 16'd10);
        rd(3'd3);
        lit("reread3", 16'd10);
        rd(3'd2);
        lit("reread2", 16'd2);

        // Different-address read-during-write
        step(1, 1, 1, 1, 3'd1, 16'h0055, 3'd6);
        lit("rdw_diff_read6", 16'd6);
        rd(3'd1);
        lit("rdw_diff_read1", 16'h0055);

        // Same-address collision beyond the short bank's height
        step(1, 1, 1, 1, 3'd6, 16'h1234, 3'd6);
        lit("rdw_same6", 16'h1234);
        lit_small("rdw_same6_oor", 16'h0);
        step(1, 1, 1, 0, 3'd7, 16'hBEEF, 3'd0);
        step(1, 1, 0, 1, 3'd0, 16'h0, 3'd7);
        lit("oor_write7", 16'hBEEF);
        lit_small("oor_write7", 16'h0);

        // Enable gating: nothing moves
        rd(3'd4);
        step(1, 0, 1, 1, 3'd5, 16'hFFFF, 3'd0);
        lit("gated_hold", 16'd4);
        rd(3'd5);
        lit("gated_mem5", 16'd5);

        // Hold with re=0 while writing elsewhere
        step(1, 1, 1, 0, 3'd0, 16'h0777, 3'd5);
        lit("hold_re0", 16'd5);
        rd(3'd0);
        lit("write0_landed", 16'h0777);

        // X addresses on a disabled port
        step(1, 0, 1, 1, 3'bx, 16'hDEAD, 3'bx);
        lit("x_en0", 16'h0777);
        step(1, 1, 0, 1, 3'bx, 16'hDEAD, 3'd2);
        lit("x_waddr_we0", 16'd2);
        step(1, 1, 1, 0, 3'd4, 16'h0444, 3'bx);
        lit("x_raddr_re0", 16'd2);
        rd(3'd4);
        lit("write4_landed", 16'h0444);

        // Reset mid-operation discards the concurrent write
        step(0, 1, 1, 1, 3'd2, 16'hAAAA, 3'd2);
        lit("midreset_dr", 16'h0);
        lit_small("midreset_dr", 16'h0);
        for (int k = 0; k < 8; k++) begin
            rd(3'(k));
            lit($sformatf("cleared%0d", k), 16'h0);
        end

        step(1, 0, 0, 0, 3'd0, 16'h0, 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
